// File: rtl/deconv2d_mc_if.sv
// Streaming/config/readback bundle for the multi-channel transposed-convolution engine.
// The slave side is the engine; the master side is the loader/readback logic.
interface deconv2d_mc_if #(
    parameter int unsigned N          = 4,
    parameter int unsigned K          = 3,
    parameter int unsigned PIXEL_BITS = 8,
    parameter int unsigned ACC_BITS   = 24,
    parameter int unsigned OUT_BITS   = 8
);
    localparam int unsigned AW = $clog2(N * K * N * K);
    localparam int unsigned DW = $clog2(N * K) + 1;
    localparam int unsigned SW = $clog2(K) + 1;
    localparam int unsigned HW = $clog2(ACC_BITS);

    logic                  start;
    logic [SW-1:0]         cfg_stride;
    logic                  cfg_signed;
    logic [HW-1:0]         cfg_shift;
    logic                  kern_valid;
    logic [PIXEL_BITS-1:0] kern_data;
    logic                  kern_ready;
    logic                  pix_valid;
    logic [PIXEL_BITS-1:0] pix_data;
    logic                  pix_ready;
    logic [AW-1:0]         rd_addr;
    logic [OUT_BITS-1:0]   rd_data;
    logic [DW-1:0]         out_dim;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, cfg_stride, cfg_signed, cfg_shift,
        input  kern_valid, kern_data, pix_valid, pix_data, rd_addr,
        output kern_ready, pix_ready, rd_data, out_dim, busy, done
    );

    modport master (
        output start, cfg_stride, cfg_signed, cfg_shift,
        output kern_valid, kern_data, pix_valid, pix_data, rd_addr,
        input  kern_ready, pix_ready, rd_data, out_dim, busy, done
    );
endinterface

// File: rtl/deconv2d_mc.sv
// Multi-channel transposed convolution: C channels of an NxN map are scattered through
// KxK kernels into one ((N-1)*S+K)^2 accumulator plane, read back shifted and saturated.
module deconv2d_mc #(
    parameter int unsigned N          = 4,
    parameter int unsigned K          = 3,
    parameter int unsigned C          = 2,
    parameter int unsigned PIXEL_BITS = 8,
    parameter int unsigned ACC_BITS   = 24,
    parameter int unsigned OUT_BITS   = 8
) (
    input  logic             clk,
    input  logic             rst,
    deconv2d_mc_if.slave     bus
);
    localparam int unsigned NACC = N * K * N * K;
    localparam int unsigned NW   = C * K * K;
    localparam int unsigned AW   = $clog2(NACC);
    localparam int unsigned DW   = $clog2(N * K) + 1;
    localparam int unsigned SW   = $clog2(K) + 1;
    localparam int unsigned HW   = $clog2(ACC_BITS);
    localparam int unsigned WIW  = $clog2(NW);
    localparam int unsigned KIW  = $clog2(NW + 1);
    localparam int unsigned RCW  = $clog2(N + 1);
    localparam int unsigned CHW  = $clog2(C + 1);
    localparam int unsigned TW   = $clog2(K + 1);
    localparam int unsigned XW   = ACC_BITS - PIXEL_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ACCUM, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_kern_ready, r_pix_ready, r_busy, r_done;
    logic                  w_kern_ready_nxt, w_pix_ready_nxt, w_busy_nxt, w_done_nxt;

    logic [SW-1:0]         r_stride, w_stride;
    logic                  r_signed;
    logic [HW-1:0]         r_shift;
    logic [DW-1:0]         r_out_dim;
    logic [KIW-1:0]        r_kidx;
    logic [RCW-1:0]        r_row, r_col;
    logic [CHW-1:0]        r_ch;
    logic [TW-1:0]         r_kr, r_kc;
    logic [PIXEL_BITS-1:0] r_pix;
    logic [PIXEL_BITS-1:0] r_kern [NW];
    logic [ACC_BITS-1:0]   r_acc  [NACC];

    logic                  w_kern_acc, w_pix_acc, w_last_tap, w_last_pix, w_start;
    logic [AW-1:0]         w_acc_idx;
    logic [WIW-1:0]        w_widx;
    logic [ACC_BITS-1:0]   w_pix_ext, w_wgt_ext, w_prod;
    logic                  w_rd_hit;
    logic [ACC_BITS-1:0]   w_rd_raw, w_rd_sh;
    logic [OUT_BITS-1:0]   w_rd_out;

    assign w_start    = (r_state == S_IDLE) && bus.start;
    assign w_kern_acc = bus.kern_valid && r_kern_ready;
    assign w_pix_acc  = bus.pix_valid && r_pix_ready;
    assign w_last_tap = (r_kr == TW'(K - 1)) && (r_kc == TW'(K - 1));
    assign w_last_pix = (r_row == RCW'(N - 1)) && (r_col == RCW'(N - 1)) && (r_ch == CHW'(C - 1));

    // Stride 0 behaves as 1; anything wider than the kernel is clamped to K.
    always_comb begin
        w_stride = bus.cfg_stride;
        if (bus.cfg_stride == '0)
            w_stride = SW'(1);
        else if (bus.cfg_stride > SW'(K))
            w_stride = SW'(K);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_kern_acc && (r_kidx == KIW'(NW - 1))) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_pix_acc) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_last_tap) w_state_nxt = w_last_pix ? S_DONE : S_WAIT;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered flags line up with the state.
    always_comb begin
        w_kern_ready_nxt = 1'b0;
        w_pix_ready_nxt  = 1'b0;
        w_done_nxt       = 1'b0;
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_LOAD:  w_kern_ready_nxt = 1'b1;
            S_WAIT:  w_pix_ready_nxt  = 1'b1;
            S_DONE:  w_done_nxt       = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kern_ready <= 1'b0;
            r_pix_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_kern_ready <= w_kern_ready_nxt;
            r_pix_ready  <= w_pix_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Job configuration plus kernel-load, position/channel and tap counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stride  <= SW'(1);
            r_signed  <= 1'b0;
            r_shift   <= '0;
            r_out_dim <= DW'(K);
            r_kidx    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_ch      <= '0;
            r_kr      <= '0;
            r_kc      <= '0;
            r_pix     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_stride  <= w_stride;
                    r_signed  <= bus.cfg_signed;
                    r_shift   <= bus.cfg_shift;
                    r_out_dim <= DW'((N - 1) * 32'(w_stride) + K);
                    r_kidx    <= '0;
                    r_row     <= '0;
                    r_col     <= '0;
                    r_ch      <= '0;
                end
                S_LOAD: if (w_kern_acc) r_kidx <= r_kidx + KIW'(1);
                S_WAIT: if (w_pix_acc) begin
                    r_pix <= bus.pix_data;
                    r_kr  <= '0;
                    r_kc  <= '0;
                end
                S_ACCUM: begin
                    if (r_kc == TW'(K - 1)) begin
                        r_kc <= '0;
                        r_kr <= r_kr + TW'(1);
                    end else begin
                        r_kc <= r_kc + TW'(1);
                    end
                    if (w_last_tap) begin
                        if (r_ch == CHW'(C - 1)) begin
                            r_ch <= '0;
                            if (r_col == RCW'(N - 1)) begin
                                r_col <= '0;
                                r_row <= r_row + RCW'(1);
                            end else begin
                                r_col <= r_col + RCW'(1);
                            end
                        end else begin
                            r_ch <= r_ch + CHW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NW); i++) r_kern[i] <= '0;
        end else if ((r_state == S_LOAD) && w_kern_acc) begin
            r_kern[WIW'(r_kidx)] <= bus.kern_data;
        end
    end

    // Operands are extended to full accumulator width; the low ACC_BITS of the product are exact.
    assign w_widx    = WIW'(32'(r_ch) * (K * K) + 32'(r_kr) * K + 32'(r_kc));
    assign w_wgt_ext = r_signed ? {{XW{r_kern[w_widx][PIXEL_BITS-1]}}, r_kern[w_widx]}
                                : {{XW{1'b0}}, r_kern[w_widx]};
    assign w_pix_ext = r_signed ? {{XW{r_pix[PIXEL_BITS-1]}}, r_pix} : {{XW{1'b0}}, r_pix};
    assign w_prod    = w_pix_ext * w_wgt_ext;
    assign w_acc_idx = AW'((32'(r_row) * 32'(r_stride) + 32'(r_kr)) * 32'(r_out_dim)
                           + 32'(r_col) * 32'(r_stride) + 32'(r_kc));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NACC); i++) r_acc[i] <= '0;
        end else if (w_start) begin
            for (int i = 0; i < int'(NACC); i++) r_acc[i] <= '0;
        end else if (r_state == S_ACCUM) begin
            r_acc[w_acc_idx] <= r_acc[w_acc_idx] + w_prod;
        end
    end

    // Readback: out-of-plane addresses read as zero, then shift and clamp to OUT_BITS.
    assign w_rd_hit = (32'(bus.rd_addr) < 32'(r_out_dim) * 32'(r_out_dim));
    assign w_rd_raw = w_rd_hit ? r_acc[bus.rd_addr] : '0;

    always_comb begin
        w_rd_sh = w_rd_raw >> r_shift;
        if (r_signed) w_rd_sh = ACC_BITS'($signed(w_rd_raw) >>> r_shift);
        w_rd_out = w_rd_sh[OUT_BITS-1:0];
        if (r_signed) begin
            if ((w_rd_sh[ACC_BITS-1:OUT_BITS-1] != '0) && (w_rd_sh[ACC_BITS-1:OUT_BITS-1] != '1))
                w_rd_out = w_rd_sh[ACC_BITS-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                                               : {1'b0, {(OUT_BITS-1){1'b1}}};
        end else if (w_rd_sh[ACC_BITS-1:OUT_BITS] != '0) begin
            w_rd_out = '1;
        end
    end

    assign bus.kern_ready = r_kern_ready;
    assign bus.pix_ready  = r_pix_ready;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.out_dim    = r_out_dim;
    assign bus.rd_data    = w_rd_out;
endmodule
